// File: rtl/tube_pkg.sv
// tube_pkg: shared widths, blank code and scheduler states for the tube message scheduler.
package tube_pkg;
    localparam int CHAR_W = 6;
    localparam int SLOTS = 8;
    localparam int FRAME_W = CHAR_W * SLOTS;
    localparam logic [CHAR_W-1:0] BLANK_CODE = 6'd0;
    localparam logic [FRAME_W-1:0] BLANK_FRAME = {SLOTS{BLANK_CODE}};
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
endpackage

// File: rtl/tube_fifo.sv
// tube_fifo: DEPTH x CHAR_W synchronous FIFO with occupancy count and synchronous flush.
module tube_fifo
    import tube_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [CHAR_W-1:0]        din,
    input  logic                     pop,
    output logic [CHAR_W-1:0]        dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    logic [CHAR_W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic wr, rd;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign wr = push & ~full;
    assign rd = pop & ~empty;
    assign dout = mem[rp];
    always_ff @(posedge clk) begin
        if (wr)
            mem[wp] <= din;
    end
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            if (wr)
                wp <= wp + 1'b1;
            if (rd)
                rp <= rp + 1'b1;
            count <= count + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end
endmodule

// File: rtl/tube_msg_sched.sv
// tube_msg_sched: buffers decoded characters and scrolls them into the 8-slot tube frame once per tick.
// Define TUBE_SCROLL_BLANK_EN to scroll the message off with blanks after the last character.
module tube_msg_sched
    import tube_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [CHAR_W-1:0]        in_data,
    output logic                     in_ready,
    input  logic                     clear,
    input  logic                     pause,
    output logic [FRAME_W-1:0]       frame,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [TW-1:0] tcnt;
    logic tick, push, pop, full, empty, last_pop, drain_shift;
    logic [CHAR_W-1:0] head;
    logic [FRAME_W-1:0] frame_nxt;
    state_t state, nxt, leave;
    assign tick = ~pause & (tcnt == TW'(TICK_DIV - 1));
    assign in_ready = rst & ~clear & ~full;
    assign push = in_valid & in_ready;
    assign pop = tick & ~empty & (state != S_DRAIN);
    // FIFO ends up empty after this edge's pop
    assign last_pop = pop & ~push & (count == CW'(1));
    assign busy = (count != '0) | (state == S_DRAIN);
`ifdef TUBE_SCROLL_BLANK_EN
    assign drain_shift = tick & (state == S_DRAIN);
    assign leave = (frame_nxt != BLANK_FRAME) ? S_DRAIN : S_IDLE;
`else
    assign drain_shift = 1'b0;
    assign leave = S_IDLE;
`endif
    assign frame_nxt = pop ? {frame[FRAME_W-CHAR_W-1:0], head} :
                       drain_shift ? {frame[FRAME_W-CHAR_W-1:0], BLANK_CODE} : frame;
    tube_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .flush(clear),
        .push(push),
        .din(in_data),
        .pop(pop),
        .dout(head),
        .count(count),
        .full(full),
        .empty(empty)
    );
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  nxt = (count == '0) ? S_IDLE : (last_pop ? leave : S_RUN);
            S_RUN:   nxt = (count == '0 || last_pop) ? leave : S_RUN;
            S_DRAIN: nxt = (count != '0) ? S_RUN : ((frame_nxt == BLANK_FRAME) ? S_IDLE : S_DRAIN);
            default: nxt = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            state <= S_IDLE;
            frame <= BLANK_FRAME;
            tcnt <= '0;
        end else begin
            state <= nxt;
            frame <= frame_nxt;
            tcnt <= pause ? tcnt : (tick ? '0 : tcnt + 1'b1);
        end
    end
endmodule

// File: tb/tb_tube_msg_sched.sv
// tb_tube_msg_sched: directed and random stimulus checked against a queue/slot-array model of the scheduler.
module tb_tube_msg_sched;
    logic clk = 1'b0;
    logic rst, in_valid, clear, pause, in_ready, busy;
    logic [5:0] in_data;
    logic [47:0] frame;
    logic [2:0] count;
    int total = 0;
    int bad = 0;
    int mq[$];
    logic [5:0] ms[8];
    int mt;
    bit mdrain;

    tube_msg_sched #(.DEPTH(4), .TICK_DIV(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .clear(clear), .pause(pause), .frame(frame), .count(count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [47:0] mframe();
        logic [47:0] f = '0;
        for (int k = 0; k < 8; k++) f[6*k +: 6] = ms[k];
        return f;
    endfunction

    function automatic void mshift(input logic [5:0] c);
        for (int k = 7; k > 0; k--) ms[k] = ms[k-1];
        ms[0] = c;
    endfunction

    function automatic void mreset();
        mq.delete();
        for (int k = 0; k < 8; k++) ms[k] = 6'd0;
        mt = 0;
        mdrain = 0;
    endfunction

    task automatic step(input bit r, input bit v, input logic [5:0] d, input bit c, input bit p);
        bit tk, popped;
        int old;
        rst = r; in_valid = v; in_data = d; clear = c; pause = p;
        #1;
        chk("in_ready", {47'd0, in_ready}, {47'd0, r && !c && mq.size() != 4});
        @(posedge clk);
        if (!r || c) mreset();
        else begin
            tk = !p && mt == 3;
            if (!p) mt = (mt + 1) % 4;
            old = mq.size();
            popped = 0;
            if (tk) begin
                if (mdrain) mshift(6'd0);
                else if (old != 0) begin mshift(6'(mq.pop_front())); popped = 1; end
            end
            if (v && old != 4) mq.push_back(int'(d));
`ifdef TUBE_SCROLL_BLANK_EN
            if (mdrain) mdrain = old == 0 && mframe() != '0;
            else mdrain = popped && mq.size() == 0 && mframe() != '0;
`endif
        end
        #1;
        chk("frame", frame, mframe());
        chk("count", {45'd0, count}, 48'(mq.size()));
        chk("busy", {47'd0, busy}, {47'd0, mq.size() != 0 || mdrain});
    endtask

    task automatic wait_count(input int target, input int limit);
        int n = 0;
        while (int'(count) != target && n < limit) begin
            step(1, 0, 6'd0, 0, 0);
            n++;
        end
        chk("wait_count", {45'd0, count}, 48'(target));
    endtask

    initial begin
        mreset();
        rst = 0; in_valid = 1; in_data = 6'd9; clear = 0; pause = 0;
        repeat (3) step(0, 1, 6'd9, 0, 0);
        chk("rst_frame", frame, 48'd0);
        // scroll: pushes start on the first edge after release
        step(1, 1, 6'd1, 0, 0);
        step(1, 1, 6'd2, 0, 0);
        step(1, 1, 6'd3, 0, 0);
        chk("peak", {45'd0, count}, 48'd3);
        wait_count(0, 40);
        chk("scroll", {30'd0, frame[17:0]}, {30'd0, 6'd1, 6'd2, 6'd3});
        // full while paused
        for (int i = 0; i < 5; i++) step(1, 1, 6'(10 + i), 0, 1);
        chk("full_cnt", {45'd0, count}, 48'd4);
        chk("full_rdy", {47'd0, in_ready}, 48'd0);
        wait_count(2, 40);
        step(1, 1, 6'd33, 1, 0);
        chk("clr_frame", frame, 48'd0);
        step(1, 0, 6'd0, 0, 0);
        // drain or hold after a single character
        step(1, 1, 6'd5, 0, 0);
        wait_count(0, 40);
        chk("single", {42'd0, frame[5:0]}, 48'd5);
        repeat (40) step(1, 0, 6'd0, 0, 0);
        chk("idle_busy", {47'd0, busy}, 48'd0);
        // reset mid-run
        step(1, 1, 6'd7, 0, 0);
        step(1, 1, 6'd8, 0, 0);
        step(1, 1, 6'd9, 0, 0);
        step(0, 1, 6'd4, 0, 0);
        chk("rst_mid", frame, 48'd0);
        for (int i = 0; i < 3000; i++) begin
            int ph = (i / 200) % 3;
            bit v = (ph == 0) ? ($urandom_range(0, 1) == 1) : (ph == 1) ? ($urandom_range(0, 7) == 0) : 1'b1;
            step($urandom_range(0, 150) != 0, v, 6'($urandom), $urandom_range(0, 60) == 0,
                 (ph == 2) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tube_msg_sched.md
# tube_msg_sched

Message scheduler for the 8-digit tube display in the Morse decoder path. Accepts decoded 6-bit character codes over a valid/ready handshake and buffers them in a small FIFO. Scrolls them into the 48-bit, 8-slot frame that feeds the letter-mode `shown2` input of the display driver, one slot per scroll tick. Owns clear/pause sequencing so the decoder never writes the display directly.

## Interface
- `DEPTH`, default 8: FIFO depth in characters. Power of two, ≥2.
- `TICK_DIV`, default 50_000_000: scroll period in `clk` cycles. ≥2.
- `clk`  in  1: system clock. Single clock domain.
- `rst`  in  1: reset, synchronous and active-low (asserted when 0).
- `in_valid`  in  1: character offered.
- `in_data`  in  6: character code.
- `in_ready`  out  1: FIFO can accept.
- `clear`  in  1: synchronous flush request, level-sensitive.
- `pause`  in  1: freeze scrolling.
- `frame`  out  48: display frame to `shown2`. Slot k is `frame[6k+5:6k]`.
- `count`  out  $clog2(DEPTH)+1: FIFO occupancy.
- `busy`  out  1: work pending.

## Operation
- Push: a character is transferred when `in_valid & in_ready` is high at a rising edge.
- `in_ready` = `rst` & ~`clear` & (`count` != `DEPTH`). A push at full is refused even if a pop occurs in the same cycle.
- Tick counter: counts 0..`TICK_DIV`-1 and wraps. `tick` pulses for one cycle at `TICK_DIV`-1.
  - `pause`=1 holds the counter, so no ticks occur.
  - `clear` resets the counter to 0.
- Shift on tick: `frame` <= {`frame[41:0]`, `new`}. Slot 0 receives the new character; slot 7 is discarded.
- FSM states:
  - S_IDLE: FIFO empty, `frame` static. Goes to S_RUN when `count` != 0.
  - S_RUN: on each tick, pop the FIFO head into slot 0. Leaves when the FIFO is empty after a pop. Goes to S_DRAIN if `TUBE_SCROLL_BLANK_EN` is defined and `frame` is not all BLANK_CODE; otherwise goes to S_IDLE.
  - S_DRAIN (macro only): on each tick, shift in BLANK_CODE. Goes to S_RUN if `count` != 0. Goes to S_IDLE when `frame` is all BLANK_CODE.
- Pop decision uses the registered `count`. A character pushed in the same cycle as a tick into an empty FIFO is not popped until the next tick.
- Simultaneous push and pop at 0 < `count` < `DEPTH`: both happen and `count` is unchanged.
- `clear` has highest priority after reset:
  - FIFO is emptied and `count`=0.
  - `frame` is set to all BLANK_CODE and the FSM goes to S_IDLE.
  - Pushes are refused for the whole cycle.
- `busy` = (`count` != 0) | (state == S_DRAIN).

## Timing
- Reset values: `frame`=48'h0 (all BLANK_CODE=6'd0), `count`=0, `busy`=0, state S_IDLE, tick counter 0. `in_ready`=0 while `rst`=0.
- Reset asserted mid-operation discards FIFO contents and frame at the next edge. There is no partial shift.
- All outputs except `in_ready` are registered. `in_ready` is combinational from `rst`, `clear` and registered `count`.
- Push-to-display latency: the first tick edge after the character reaches the FIFO head.
- Worst case for a push into an empty FIFO is `TICK_DIV` cycles.
- `frame` changes only at tick edges, at `clear`, or at reset.

## Configuration
- `TUBE_SCROLL_BLANK_EN` defined:
  - After the last character, blanks continue shifting in, one per tick, until the frame is empty.
  - The message scrolls fully off within 8 ticks, and `busy` stays high until then.
- `TUBE_SCROLL_BLANK_EN` undefined:
  - S_DRAIN does not exist, and the last 8 characters hold on the display indefinitely.
  - `busy` reflects the FIFO only.

## Structure
- Package `tube_pkg`:
  - `CHAR_W`=6, `SLOTS`=8, `BLANK_CODE`=6'd0.
  - FSM state enum {S_IDLE, S_RUN, S_DRAIN}.
- Sub-module `tube_fifo`: synchronous FIFO of `DEPTH`×`CHAR_W` with push/pop, `count`, full and empty, and a synchronous flush.
- The tick counter, FSM and frame shift register stay in `tube_msg_sched`.

## Test plan
All scenarios use `TICK_DIV`=4 and `DEPTH`=4.
- Reset: hold `rst`=0 for 3 cycles with `in_valid`=1. Expect `in_ready`=0, `frame`=0, `count`=0, `busy`=0, and nothing accepted. After release, `in_ready`=1.
- Scroll: push codes 1, 2, 3 back-to-back. Expect `count` to peak at 3. After 3 ticks, `frame[17:0]`={6'd1,6'd2,6'd3}, `count`=0, and `frame` is unchanged between ticks.
- Full: with `pause`=1, offer 5 characters. Expect 4 accepted, `in_ready`=0 on the 5th, `count`=4, and `frame` unchanged. Release `pause`: one pop per 4 cycles.
- Clear: in S_RUN with `count`=2, assert `clear` for 1 cycle with `in_valid`=1. Expect no push that cycle, then `count`=0, `frame`=0, S_IDLE, and `in_ready`=1 the next cycle.
- Drain (macro defined): push code 5. After 1 tick, `frame[5:0]`=5. After 7 more ticks, `frame[47:42]`=5. After 1 further tick, `frame`=0 and `busy`=0. With the macro undefined, `frame[5:0]` stays 5 and `busy`=0 after the pop.
- Reset mid-run: assert `rst`=0 with `count`=3 and `frame` non-zero. Expect all reset values at the next edge, and no pop or shift on a coincident tick.
